// File: rtl/sfu_commit_arbiter_pkg.sv
// Shared SFU commit-source constants and payload layout for the SFU commit arbiter.
// The rr_next helper gives the round-robin successor of a source index.
package sfu_commit_arbiter_pkg;

  localparam int SFU_NUM_COMMIT_SRCS = 2;
  localparam int SFU_SRC_CSR         = 0;
  localparam int SFU_SRC_WCTL        = 1;

  typedef struct packed {
    logic [7:0]  uuid;
    logic [3:0]  wid;
    logic [3:0]  tmask;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb;
    logic [7:0]  data;
    logic        pid;
    logic        rrs_id;
  } commit_payload_t;

  localparam int COMMIT_DATAW = $bits(commit_payload_t);

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/sfu_commit_arbiter_chk.sv
// Protocol checker for the SFU commit arbiter: flags a sop beat accepted from
// the lock owner while a packet is still open.
module sfu_commit_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic locked_i,
  input logic fire_i,
  input logic sop_i
);

  a_no_sop_while_locked: assert property (@(posedge clk) disable iff (reset)
    !(locked_i && fire_i && sop_i));

endmodule

// File: rtl/sfu_rr_picker.sv
// Combinational round-robin selector: first valid request scanning upward from
// ptr_i with wrap-around; returns a one-hot grant and its index.
module sfu_rr_picker #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [GW-1:0] ptr_i,
  output logic          grant_valid_o,
  output logic [GW-1:0] grant_idx_o,
  output logic [N-1:0]  grant_oh_o
);

  // Scan priority order starting at the pointer, stop at the first hit.
  always_comb begin
    logic found;
    int   idx;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && valid_i[idx]) begin
        found           = 1'b1;
        grant_idx_o     = GW'(idx);
        grant_oh_o[idx] = 1'b1;
      end else begin
        found = found;
      end
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/sfu_commit_arbiter.sv
// Round-robin, packet-locking merge of SFU commit streams into one commit port.
// Optional stall counter output enabled by defining SFU_COMMIT_ARB_PERF_EN.
module sfu_commit_arbiter
  import sfu_commit_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = SFU_NUM_COMMIT_SRCS,
  parameter  int DATAW      = COMMIT_DATAW,
  parameter  int OUT_BUF    = 1,
  localparam int GW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_sop,
  input  logic [NUM_INPUTS-1:0]       in_eop,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [DATAW-1:0]            out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  input  logic                        out_ready,
  output logic [GW-1:0]               grant_idx
`ifdef SFU_COMMIT_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_stalls
`endif
);

  logic                  locked_q, locked_d;
  logic [GW-1:0]         lock_idx_q, lock_idx_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_idx_q, grant_idx_d;

  logic                  pick_valid_s;
  logic [GW-1:0]         pick_idx_s;
  logic [NUM_INPUTS-1:0] pick_oh_s;
  logic [NUM_INPUTS-1:0] grant_oh_s;
  logic [GW-1:0]         grant_s;
  logic                  grant_valid_s;
  logic                  buf_ready_s;
  logic                  fire_s;
  logic [DATAW-1:0]      sel_data_s;
  logic                  sel_sop_s;
  logic                  sel_eop_s;

  sfu_rr_picker #(
    .N  (NUM_INPUTS),
    .GW (GW)
  ) u_picker (
    .valid_i       (in_valid),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (pick_valid_s),
    .grant_idx_o   (pick_idx_s),
    .grant_oh_o    (pick_oh_s)
  );

  // While a packet is open the owner keeps the grant even when it idles.
  assign grant_valid_s = locked_q | pick_valid_s;
  assign grant_s       = locked_q ? lock_idx_q : pick_idx_s;
  assign grant_oh_s    = locked_q ? (NUM_INPUTS'(1) << lock_idx_q) : pick_oh_s;
  assign in_ready      = grant_oh_s & {NUM_INPUTS{buf_ready_s & ~reset}};
  assign fire_s        = |(in_valid & in_ready);
  assign sel_data_s    = in_data[int'(grant_s)*DATAW +: DATAW];
  assign sel_sop_s     = in_sop[grant_s];
  assign sel_eop_s     = in_eop[grant_s];

  // Lock and pointer bookkeeping driven by the accepted beat's sop/eop.
  always_comb begin
    locked_d    = locked_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    if (fire_s) begin
      grant_idx_d = grant_s;
      if (sel_eop_s) begin
        locked_d = 1'b0;
        rr_ptr_d = GW'(rr_next(32'(grant_s), NUM_INPUTS));
      end else if (sel_sop_s && !locked_q) begin
        locked_d   = 1'b1;
        lock_idx_d = grant_s;
      end else begin
        locked_d = locked_q;
      end
    end else begin
      grant_idx_d = grant_idx_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q    <= 1'b0;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      locked_q    <= locked_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant_idx = grant_idx_q;

  generate
    if (OUT_BUF != 0) begin : g_buf
      logic [DATAW+1:0] mem_q [2];
      logic             wr_q;
      logic             rd_q;
      logic [1:0]       cnt_q;
      logic             pop_s;

      // buf_ready comes only from the occupancy register, so out_ready never
      // reaches in_ready combinationally.
      assign pop_s       = out_valid & out_ready;
      assign buf_ready_s = (cnt_q != 2'd2);
      assign out_valid   = (cnt_q != 2'd0);
      assign {out_sop, out_eop, out_data} = mem_q[rd_q];

      // Two-entry circular store with occupancy count.
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_q[0] <= '0;
          mem_q[1] <= '0;
          wr_q     <= 1'b0;
          rd_q     <= 1'b0;
          cnt_q    <= 2'd0;
        end else begin
          if (fire_s) begin
            mem_q[wr_q] <= {sel_sop_s, sel_eop_s, sel_data_s};
            wr_q        <= ~wr_q;
          end
          if (pop_s) begin
            rd_q <= ~rd_q;
          end
          cnt_q <= cnt_q + {1'b0, fire_s} - {1'b0, pop_s};
        end
      end
    end else begin : g_pass
      assign buf_ready_s = out_ready;
      assign out_valid   = grant_valid_s & in_valid[grant_s] & ~reset;
      assign out_data    = sel_data_s;
      assign out_sop     = sel_sop_s;
      assign out_eop     = sel_eop_s;
    end
  endgenerate

`ifdef SFU_COMMIT_ARB_PERF_EN
  logic [31:0] perf_q;
  logic        stall_s;

  assign stall_s     = (|in_valid) & ~fire_s;
  assign perf_stalls = perf_q;

  // Saturating count of cycles with pending requests but no transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else if (stall_s && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end
`endif

  sfu_commit_arbiter_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .locked_i (locked_q),
    .fire_i   (fire_s),
    .sop_i    (sel_sop_s)
  );

endmodule

// File: tb/tb_sfu_commit_arbiter.sv
// Directed, table-driven bench for sfu_commit_arbiter (2 sources, 64-bit payload,
// output buffer enabled) plus hand-written backpressure and reset sequences.
module tb_sfu_commit_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_valid;
  logic [127:0] in_data;
  logic [1:0]   in_sop;
  logic [1:0]   in_eop;
  logic [1:0]   in_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_sop;
  logic         out_eop;
  logic         out_ready;
  logic [0:0]   grant_idx;

  int checks   = 0;
  int failures = 0;

  sfu_commit_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] sop;
    logic [1:0] eop;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_d;
    logic       exp_sop;
    logic       exp_eop;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] r,
                              input logic ov, input logic [7:0] od, input logic os, input logic oe);
    vec_t t;
    t.valid = v; t.sop = s; t.eop = e; t.d0 = d0; t.d1 = d1;
    t.exp_rdy = r; t.exp_ov = ov; t.exp_d = od; t.exp_sop = os; t.exp_eop = oe;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                       input logic [63:0] d0, input logic [63:0] d1);
    in_valid = v; in_sop = s; in_eop = e; in_data = {d1, d0};
  endtask

  logic [63:0] bp_exp [6];
  int sent0, sent1, accepted, got;

  initial begin
    // single beat, contention, 4-beat lock, idle owner
    vecs[0]  = mk(2'b01, 2'b01, 2'b01, 8'h11, 8'h00, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[1]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 8'h11, 1'b1, 1'b1);
    vecs[2]  = mk(2'b11, 2'b11, 2'b11, 8'h20, 8'h21, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[3]  = mk(2'b11, 2'b11, 2'b11, 8'h22, 8'h23, 2'b01, 1'b1, 8'h21, 1'b1, 1'b1);
    vecs[4]  = mk(2'b11, 2'b11, 2'b11, 8'h24, 8'h25, 2'b10, 1'b1, 8'h22, 1'b1, 1'b1);
    vecs[5]  = mk(2'b11, 2'b11, 2'b11, 8'h26, 8'h27, 2'b01, 1'b1, 8'h25, 1'b1, 1'b1);
    vecs[6]  = mk(2'b10, 2'b10, 2'b10, 8'h00, 8'h28, 2'b10, 1'b1, 8'h26, 1'b1, 1'b1);
    vecs[7]  = mk(2'b11, 2'b11, 2'b10, 8'h30, 8'h40, 2'b01, 1'b1, 8'h28, 1'b1, 1'b1);
    vecs[8]  = mk(2'b11, 2'b10, 2'b10, 8'h31, 8'h40, 2'b01, 1'b1, 8'h30, 1'b1, 1'b0);
    vecs[9]  = mk(2'b11, 2'b10, 2'b10, 8'h32, 8'h40, 2'b01, 1'b1, 8'h31, 1'b0, 1'b0);
    vecs[10] = mk(2'b11, 2'b10, 2'b11, 8'h33, 8'h40, 2'b01, 1'b1, 8'h32, 1'b0, 1'b0);
    vecs[11] = mk(2'b11, 2'b11, 2'b11, 8'h34, 8'h40, 2'b10, 1'b1, 8'h33, 1'b0, 1'b1);
    vecs[12] = mk(2'b11, 2'b11, 2'b10, 8'h50, 8'h42, 2'b01, 1'b1, 8'h40, 1'b1, 1'b1);
    vecs[13] = mk(2'b10, 2'b10, 2'b10, 8'h00, 8'h42, 2'b01, 1'b1, 8'h50, 1'b1, 1'b0);
    vecs[14] = mk(2'b10, 2'b10, 2'b10, 8'h00, 8'h42, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[15] = mk(2'b10, 2'b10, 2'b10, 8'h00, 8'h42, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[16] = mk(2'b11, 2'b10, 2'b11, 8'h51, 8'h42, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[17] = mk(2'b10, 2'b10, 2'b10, 8'h00, 8'h42, 2'b10, 1'b1, 8'h51, 1'b0, 1'b1);
    vecs[18] = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 8'h42, 1'b1, 1'b1);
    vecs[19] = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

    bp_exp[0] = 64'h100; bp_exp[1] = 64'h200; bp_exp[2] = 64'h101;
    bp_exp[3] = 64'h201; bp_exp[4] = 64'h102; bp_exp[5] = 64'h202;

    // Reset with requests pending: nothing may be accepted.
    reset = 1'b1; out_ready = 1'b1;
    drive(2'b11, 2'b11, 2'b11, 64'h1, 64'h2);
    tick(); tick();
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_grant_idx", 64'(grant_idx), 64'h0);
    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].sop, vecs[i].eop, {56'h0, vecs[i].d0}, {56'h0, vecs[i].d1});
      out_ready = 1'b1;
      #2;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
        chk($sformatf("v%0d_out_data", i), out_data, {56'h0, vecs[i].exp_d});
        chk($sformatf("v%0d_out_sop", i), 64'(out_sop), 64'(vecs[i].exp_sop));
        chk($sformatf("v%0d_out_eop", i), 64'(out_eop), 64'(vecs[i].exp_eop));
      end
      tick();
    end

    // Backpressure: five stalled cycles, both sources streaming single beats.
    sent0 = 0; sent1 = 0; accepted = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive({sent1 < 3, sent0 < 3}, 2'b11, 2'b11, 64'h100 + 64'(sent0), 64'h200 + 64'(sent1));
      #2;
      if (c >= 2) chk($sformatf("bp_stall%0d_in_ready", c), 64'(in_ready), 64'h0);
      if (in_valid[0] && in_ready[0]) begin sent0++; accepted++; end
      if (in_valid[1] && in_ready[1]) begin sent1++; accepted++; end
      tick();
    end
    chk("bp_buffered", 64'(accepted), 64'd2);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      drive({sent1 < 3, sent0 < 3}, 2'b11, 2'b11, 64'h100 + 64'(sent0), 64'h200 + 64'(sent1));
      #2;
      if (out_valid) begin
        chk($sformatf("bp_out%0d", got), out_data, bp_exp[got]);
        got++;
      end
      if (in_valid[0] && in_ready[0]) sent0++;
      if (in_valid[1] && in_ready[1]) sent1++;
      tick();
    end
    chk("bp_drained", 64'(got), 64'd6);
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    #2;
    chk("bp_no_dup", 64'(out_valid), 64'h0);
    tick();

    // Reset in the middle of a src1 packet.
    drive(2'b10, 2'b10, 2'b00, 64'h0, 64'h60);
    #2;
    chk("rp_sop_ready", 64'(in_ready), 64'h2);
    tick();
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    #2;
    chk("rp_gidx_before", 64'(grant_idx), 64'h1);
    chk("rp_ov_before", 64'(out_valid), 64'h1);
    tick();
    reset = 1'b0;
    drive(2'b11, 2'b01, 2'b01, 64'h70, 64'h61);
    #2;
    chk("rp_out_valid", 64'(out_valid), 64'h0);
    chk("rp_locked", 64'(dut.locked_q), 64'h0);
    chk("rp_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    chk("rp_grant_idx", 64'(grant_idx), 64'h0);
    chk("rp_src0_granted", 64'(in_ready), 64'h1);
    tick();
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    #2;
    chk("rp_after_valid", 64'(out_valid), 64'h1);
    chk("rp_after_data", out_data, 64'h70);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
